// File: rtl/pll_drp_reconfig_if.sv
// DRP bus plus PLL reset/lock pins between the reconfiguration sequencer (master)
// and the pll core (slave).
interface pll_drp_reconfig_if;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den;
    logic        dwe;
    logic [15:0] dout;
    logic        drdy;
    logic        pll_rst;
    logic        locked;

    modport master (
        output daddr, di, den, dwe, pll_rst,
        input  dout, drdy, locked
    );

    modport slave (
        input  daddr, di, den, dwe, pll_rst,
        output dout, drdy, locked
    );
endinterface

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration sequencer: holds the pll in reset, read-modify-writes a table of
// (address, keep-mask, data) entries over DRP, releases reset and waits for LOCKED.
module pll_drp_reconfig #(
    parameter int DEPTH        = 8,
    parameter int IDX_W        = 3,
    parameter int RST_CYCLES   = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W:0]     num_entries,
    input  logic               tbl_we,
    input  logic [IDX_W-1:0]   tbl_idx,
    input  logic [6:0]         tbl_addr,
    input  logic [15:0]        tbl_mask,
    input  logic [15:0]        tbl_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    pll_drp_reconfig_if.master drp
);

    localparam int CNT_MAX_RD = (DRDY_TIMEOUT > RST_CYCLES) ? DRDY_TIMEOUT : RST_CYCLES;
    localparam int CNT_MAX    = (LOCK_TIMEOUT > CNT_MAX_RD) ? LOCK_TIMEOUT : CNT_MAX_RD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST   = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_IGNORE = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W:0]   DEPTH_N     = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   IDX_ONE     = (IDX_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_WAIT_LOCK
    } state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } entry_t;

    entry_t           table_mem [DEPTH];
    entry_t           cur;
    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W:0]   n_q, idx, idx_inc;
    logic [IDX_W-1:0] sel_next;
    logic             low_seen;
    logic [6:0]       daddr_q;
    logic [15:0]      di_q;
    logic             pll_rst_q;

    logic accept, cnt_clr, rd_capture, step, release_rst, finish_ok, finish_err;

    assign idx_inc  = idx + IDX_ONE;
    assign cur      = table_mem[idx[IDX_W-1:0]];
    assign sel_next = step ? idx_inc[IDX_W-1:0] : idx[IDX_W-1:0];

    assign busy        = (state != S_IDLE);
    assign drp.den     = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign drp.dwe     = (state == S_WR_REQ);
    assign drp.daddr   = daddr_q;
    assign drp.di      = di_q;
    assign drp.pll_rst = pll_rst_q;

    // NOTE: the table is plain storage with no reset so it maps onto distributed RAM;
    // its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (tbl_we && state == S_IDLE && int'(tbl_idx) < DEPTH)
            table_mem[tbl_idx] <= {tbl_addr, tbl_mask, tbl_data};
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        cnt_clr     = 1'b0;
        rd_capture  = 1'b0;
        step        = 1'b0;
        release_rst = 1'b0;
        finish_ok   = 1'b0;
        finish_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                // the DONE cycle is still IDLE, but a START there must not restart
                if (start && !done) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = S_HOLD_RST;
                end
            end
            S_HOLD_RST: begin
                if (cnt == RST_LAST) begin
                    cnt_clr = 1'b1;
                    if (n_q != '0) begin
                        next_state = S_RD_REQ;
                    end else begin
                        release_rst = 1'b1;
                        next_state  = S_WAIT_LOCK;
                    end
                end
            end
            S_RD_REQ: begin
                cnt_clr    = 1'b1;
                next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp.drdy) begin
                    rd_capture = 1'b1;
                    next_state = S_WR_REQ;
                end else if (cnt == DRDY_LAST) begin
                    finish_err = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_WR_REQ: begin
                cnt_clr    = 1'b1;
                next_state = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp.drdy) begin
                    step = 1'b1;
                    if (idx_inc == n_q) begin
                        release_rst = 1'b1;
                        cnt_clr     = 1'b1;
                        next_state  = S_WAIT_LOCK;
                    end else begin
                        next_state = S_RD_REQ;
                    end
                end else if (cnt == DRDY_LAST) begin
                    finish_err = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_WAIT_LOCK: begin
                // a LOCKED left over from before the reset took effect must not count
                if (drp.locked && (low_seen || cnt >= LOCK_IGNORE)) begin
                    finish_ok  = 1'b1;
                    next_state = S_IDLE;
                end else if (cnt == LOCK_LAST) begin
                    finish_err = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            n_q       <= '0;
            idx       <= '0;
            low_seen  <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            pll_rst_q <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= finish_ok | finish_err;

            if (cnt_clr)
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + CNT_ONE;

            if (accept) begin
                n_q       <= (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
                idx       <= '0;
                error     <= 1'b0;
                pll_rst_q <= 1'b1;
            end

            if (finish_err) begin
                error     <= 1'b1;
                pll_rst_q <= 1'b0;
            end

            if (release_rst) begin
                pll_rst_q <= 1'b0;
                low_seen  <= 1'b0;
            end else if (state == S_WAIT_LOCK && !drp.locked) begin
                low_seen <= 1'b1;
            end

            if (step)
                idx <= idx_inc;

            if (next_state == S_RD_REQ)
                daddr_q <= table_mem[sel_next].addr;

            // merge: keep-mask bits come from the pll, the rest from the table entry
            if (rd_capture)
                di_q <= (drp.dout & cur.mask) | (cur.data & ~cur.mask);
        end
    end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Self-checking bench: a DRP/PLL slave model logs every access; expected access lists and
// final register images come from a table-level read-modify-write model.
module tb_pll_drp_reconfig;
    localparam int DEPTH        = 8;
    localparam int IDX_W        = 3;
    localparam int RST_CYCLES   = 4;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 300;
    localparam int RUN_BOUND    = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W:0]   num_entries;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_idx;
    logic [6:0]       tbl_addr;
    logic [15:0]      tbl_mask;
    logic [15:0]      tbl_data;
    logic             busy, done, error;

    pll_drp_reconfig_if drp ();

    pll_drp_reconfig #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .RST_CYCLES(RST_CYCLES),
        .DRDY_TIMEOUT(DRDY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_entries(num_entries),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
        .tbl_mask(tbl_mask), .tbl_data(tbl_data),
        .busy(busy), .done(done), .error(error), .drp(drp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] wdata;
        longint      cyc;
    } acc_t;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } ent_t;

    // pll slave model state
    logic [15:0] pll_regs [128];
    logic [15:0] pend_data;
    int          cd;
    int          lk_cnt;
    int          drdy_lat   = 1;   // cycles from DEN to DRDY; 0 = never answers
    int          lock_lat   = 2;   // cycles after reset release until LOCKED; 0 = never
    bit          lock_stuck = 1'b0;
    acc_t        log_q [$];

    // reference model state
    ent_t        shadow [DEPTH];
    acc_t        exp_q [$];
    logic [15:0] exp_img [128];

    // run observations
    int first_den_k, rst_hi, release_k, lock_k, done_k;
    logic busy_k1, err_k1, err_d, busy_d, pll_d, done_after, busy_after;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drp.drdy <= 1'b0;
            drp.dout <= '0;
            cd       <= 0;
            for (int i = 0; i < 128; i++)
                pll_regs[i] <= (i == 8) ? 16'h1234 : 16'($urandom);
        end else begin
            drp.drdy <= 1'b0;
            if (drp.den) begin
                log_q.push_back('{addr: drp.daddr, we: drp.dwe, wdata: drp.di, cyc: cyc});
                pend_data <= pll_regs[drp.daddr];
                if (drp.dwe) pll_regs[drp.daddr] <= drp.di;
                if (drdy_lat == 1) begin
                    drp.drdy <= 1'b1;
                    drp.dout <= pll_regs[drp.daddr];
                    cd       <= 0;
                end else begin
                    cd <= (drdy_lat == 0) ? 0 : drdy_lat - 1;
                end
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    drp.drdy <= 1'b1;
                    drp.dout <= pend_data;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drp.locked <= 1'b0;
            lk_cnt     <= 0;
        end else if (lock_stuck) begin
            drp.locked <= 1'b1;
        end else if (drp.pll_rst) begin
            drp.locked <= 1'b0;
            lk_cnt     <= 0;
        end else if (lock_lat > 0) begin
            if (lk_cnt < lock_lat) lk_cnt <= lk_cnt + 1;
            if (lk_cnt + 1 >= lock_lat) drp.locked <= 1'b1;
        end
    end

    task automatic load_entry(input int i, input logic [6:0] a, input logic [15:0] m,
                              input logic [15:0] d);
        @(negedge clk);
        tbl_we = 1'b1; tbl_idx = i[IDX_W-1:0]; tbl_addr = a; tbl_mask = m; tbl_data = d;
        shadow[i] = '{addr: a, mask: m, data: d};
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic build_expected(input int n_req);
        int n;
        logic [15:0] nv;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        exp_q.delete();
        for (int a = 0; a < 128; a++) exp_img[a] = pll_regs[a];
        for (int i = 0; i < n; i++) begin
            nv = (exp_img[shadow[i].addr] & shadow[i].mask) | (shadow[i].data & ~shadow[i].mask);
            exp_q.push_back('{addr: shadow[i].addr, we: 1'b0, wdata: 16'h0, cyc: 0});
            exp_q.push_back('{addr: shadow[i].addr, we: 1'b1, wdata: nv, cyc: 0});
            exp_img[shadow[i].addr] = nv;
        end
    endtask

    task automatic compare_log(input string name);
        int diff;
        total++;
        if (log_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_len: got %0d accesses, expected %0d", name, log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (log_q[i].addr !== exp_q[i].addr || log_q[i].we !== exp_q[i].we ||
                    (exp_q[i].we && log_q[i].wdata !== exp_q[i].wdata)) begin
                    bad++;
                    $display("FAIL %s_acc%0d: got a=%0h we=%0b d=%0h, expected a=%0h we=%0b d=%0h",
                             name, i, log_q[i].addr, log_q[i].we, log_q[i].wdata,
                             exp_q[i].addr, exp_q[i].we, exp_q[i].wdata);
                end
            end
        end
        diff = 0;
        for (int a = 0; a < 128; a++) if (pll_regs[a] !== exp_img[a]) diff++;
        total++;
        if (diff != 0) begin
            bad++;
            $display("FAIL %s_image: %0d pll registers differ from expected", name, diff);
        end
    endtask

    task automatic run_seq(input int n, input int inject_k, input bit start_at_done);
        log_q.delete();
        first_den_k = -1; rst_hi = 0; release_k = -1; lock_k = -1; done_k = -1;
        @(negedge clk);
        num_entries = n[IDX_W:0];
        start = 1'b1;
        for (int k = 1; k <= RUN_BOUND; k++) begin
            @(negedge clk);
            start = 1'b0; tbl_we = 1'b0;
            if (k == 1) begin busy_k1 = busy; err_k1 = error; end
            if (drp.den && first_den_k < 0) first_den_k = k;
            if (drp.pll_rst) rst_hi++;
            else if (rst_hi > 0 && release_k < 0) release_k = k;
            if (release_k >= 0 && drp.locked && lock_k < 0) lock_k = k;
            if (done) begin
                done_k = k; err_d = error; busy_d = busy; pll_d = drp.pll_rst;
                if (start_at_done) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                done_after = done; busy_after = busy;
                break;
            end
            if (k == inject_k) begin
                start = 1'b1; tbl_we = 1'b1; tbl_idx = '0;
                tbl_addr = ~shadow[0].addr; tbl_mask = ~shadow[0].mask; tbl_data = ~shadow[0].data;
            end
        end
        if (done_k < 0) begin
            total++; bad++;
            $display("FAIL run_timeout: got no DONE within %0d cycles, expected DONE", RUN_BOUND);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_entries = '0; tbl_we = 1'b0;
        tbl_idx = '0; tbl_addr = '0; tbl_mask = '0; tbl_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, error, drp.den, drp.dwe, drp.pll_rst, drp.daddr, drp.di} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b den=%0b dwe=%0b prst=%0b a=%0h di=%0h, expected all 0",
                     busy, done, error, drp.den, drp.dwe, drp.pll_rst, drp.daddr, drp.di);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_entry();
        drdy_lat = 2; lock_lat = 3;
        load_entry(0, 7'h08, 16'h1000, 16'h0041);
        build_expected(1);
        run_seq(1, 0, 1'b0);
        total++;
        if (first_den_k !== RST_CYCLES + 1) begin
            bad++; $display("FAIL single_latency: got %0d, expected %0d", first_den_k, RST_CYCLES + 1);
        end
        total++;
        if (log_q.size() != 2 || log_q[1].wdata !== 16'h1041) begin
            bad++; $display("FAIL single_wdata: got %0d accesses, expected write of 1041", log_q.size());
        end
        compare_log("single");
        total++;
        if ({err_d, busy_d, pll_d, done_after, busy_k1} !== 5'b00001) begin
            bad++; $display("FAIL single_end: got err=%0b busy=%0b prst=%0b done_next=%0b busy_k1=%0b, expected 0 0 0 0 1",
                            err_d, busy_d, pll_d, done_after, busy_k1);
        end
        total++;
        if (done_k !== lock_k + 1) begin
            bad++; $display("FAIL single_done_on_lock: got %0d, expected %0d", done_k, lock_k + 1);
        end
    endtask

    task automatic test_zero_entries();
        drdy_lat = 1; lock_lat = 2;
        run_seq(0, 0, 1'b0);
        total++;
        if (rst_hi !== RST_CYCLES || release_k !== RST_CYCLES + 1) begin
            bad++; $display("FAIL zero_pll_rst: got high=%0d release=%0d, expected %0d %0d",
                            rst_hi, release_k, RST_CYCLES, RST_CYCLES + 1);
        end
        total++;
        if (log_q.size() !== 0) begin
            bad++; $display("FAIL zero_no_den: got %0d accesses, expected 0", log_q.size());
        end
        total++;
        if (err_d !== 1'b0 || done_k !== lock_k + 1) begin
            bad++; $display("FAIL zero_done: got err=%0b done=%0d, expected 0 and %0d", err_d, done_k, lock_k + 1);
        end
    endtask

    task automatic test_back_to_back();
        drdy_lat = 1; lock_lat = 1;
        for (int i = 0; i < 3; i++)
            load_entry(i, 7'($urandom), 16'($urandom), 16'($urandom));
        build_expected(3);
        run_seq(3, 0, 1'b0);
        compare_log("b2b");
        for (int i = 1; i < 6; i++) begin
            total++;
            if (log_q.size() <= i || log_q[i].cyc - log_q[0].cyc !== longint'(2 * i)) begin
                bad++; $display("FAIL b2b_spacing%0d: got %0d cycles, expected %0d", i,
                                (log_q.size() > i) ? log_q[i].cyc - log_q[0].cyc : -1, 2 * i);
            end
        end
    endtask

    task automatic test_drdy_timeout();
        drdy_lat = 0; lock_lat = 2;
        run_seq(2, 0, 1'b0);
        total++;
        if ({err_d, busy_d, pll_d, done_after} !== 4'b1000) begin
            bad++; $display("FAIL drdy_to_flags: got err=%0b busy=%0b prst=%0b done_next=%0b, expected 1 0 0 0",
                            err_d, busy_d, pll_d, done_after);
        end
        total++;
        if (log_q.size() !== 1) begin
            bad++; $display("FAIL drdy_to_accesses: got %0d, expected 1", log_q.size());
        end
        total++;
        if (done_k - first_den_k < DRDY_TIMEOUT || done_k - first_den_k > DRDY_TIMEOUT + 2) begin
            bad++; $display("FAIL drdy_to_time: got %0d cycles, expected about %0d", done_k - first_den_k, DRDY_TIMEOUT);
        end
        // a fresh START must clear the sticky error
        drdy_lat = 1;
        build_expected(2);
        run_seq(2, 0, 1'b0);
        total++;
        if (err_k1 !== 1'b0 || err_d !== 1'b0) begin
            bad++; $display("FAIL error_clear: got %0b/%0b, expected 0/0", err_k1, err_d);
        end
        compare_log("after_to");
    endtask

    task automatic test_lock();
        lock_stuck = 1'b1;
        run_seq(0, 0, 1'b0);
        total++;
        if (done_k - release_k < 2 || done_k - release_k > 3 || err_d !== 1'b0) begin
            bad++; $display("FAIL lock_stale: got done %0d cycles after release err=%0b, expected 2..3 and 0",
                            done_k - release_k, err_d);
        end
        lock_stuck = 1'b0; lock_lat = 0;
        run_seq(0, 0, 1'b0);
        total++;
        if (err_d !== 1'b1 || done_k - release_k < LOCK_TIMEOUT - 1 || done_k - release_k > LOCK_TIMEOUT + 1) begin
            bad++; $display("FAIL lock_timeout: got err=%0b after %0d cycles, expected 1 after about %0d",
                            err_d, done_k - release_k, LOCK_TIMEOUT);
        end
        lock_lat = 2;
    endtask

    task automatic test_busy_ignored();
        drdy_lat = 2; lock_lat = 2;
        build_expected(2);
        run_seq(2, 7, 1'b1);
        compare_log("busy_run");
        total++;
        if (busy_after !== 1'b0) begin
            bad++; $display("FAIL start_on_done: got busy=%0b, expected 0", busy_after);
        end
        repeat (2) @(negedge clk);
        build_expected(1);
        run_seq(1, 0, 1'b0);
        compare_log("busy_readback");
    endtask

    task automatic test_reset_mid();
        bit seen;
        drdy_lat = 3; lock_lat = 2;
        seen = 1'b0;
        @(negedge clk);
        num_entries = 4'd2; start = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (drp.den && drp.dwe) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL mid_reach_write: got no write access, expected one");
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, error, drp.den, drp.dwe, drp.pll_rst, drp.daddr, drp.di} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: got busy=%0b den=%0b prst=%0b a=%0h di=%0h, expected all 0",
                            busy, drp.den, drp.pll_rst, drp.daddr, drp.di);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            load_entry(i, 7'($urandom), 16'($urandom), 16'($urandom));
        build_expected(2);
        run_seq(2, 0, 1'b0);
        compare_log("mid_rerun");
        total++;
        if (err_d !== 1'b0) begin
            bad++; $display("FAIL mid_rerun_err: got %0b, expected 0", err_d);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < DEPTH; i++)
                load_entry(i, 7'($urandom), 16'($urandom), 16'($urandom));
            n        = $urandom_range(0, 15);
            drdy_lat = $urandom_range(1, 4);
            lock_lat = $urandom_range(1, 5);
            build_expected(n);
            run_seq(n, 0, 1'b0);
            compare_log($sformatf("rand%0d", it));
            total++;
            if (err_d !== 1'b0 || done_k !== lock_k + 1) begin
                bad++; $display("FAIL rand%0d_done: got err=%0b done=%0d, expected 0 and %0d",
                                it, err_d, done_k, lock_k + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_zero_entries();
        test_back_to_back();
        test_drdy_timeout();
        test_lock();
        test_busy_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
